// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: handshake, strobe and status bundle between the sequencer and the core datapath.
interface cpu_sequencer_if #(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 32
);
  logic               run;
  logic [INSTR_W-1:0] instr;
  logic               im_ack;
  logic               dm_ack;
  logic               cu_regw;
  logic               im_req;
  logic               dm_req;
  logic               rf_rd_en;
  logic               alu_en;
  logic               rf_wr_en;
  logic               pc_en;
  logic [INSTR_W-1:0] ir;
  logic [2:0]         state;
  logic [CNT_W-1:0]   retired;
  logic               fault;
  modport slave (
    input  run, instr, im_ack, dm_ack, cu_regw,
    output im_req, dm_req, rf_rd_en, alu_en, rf_wr_en, pc_en, ir, state, retired, fault
  );
  modport master (
    output run, instr, im_ack, dm_ack, cu_regw,
    input  im_req, dm_req, rf_rd_en, alu_en, rf_wr_en, pc_en, ir, state, retired, fault
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: mask-driven multi-cycle instruction FSM with bounded req/ack waits and a retired counter.
module cpu_sequencer #(
  parameter int                OP_W       = 4,
  parameter int                INSTR_W    = 16,
  parameter int                CNT_W      = 32,
  parameter int                MAX_WAIT   = 8,
  parameter logic [2**OP_W-1:0] MEM_MASK   = 16'h80E0,
  parameter logic [2**OP_W-1:0] JUMP_MASK  = 16'h1000,
  parameter logic [2**OP_W-1:0] SHORT_MASK = 16'h6000
) (
  input logic            clk,
  input logic            rst,
  cpu_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;
  localparam int WAIT_W = MAX_WAIT > 2 ? $clog2(MAX_WAIT) : 1;
  state_t             r_state;
  state_t             w_next;
  logic [INSTR_W-1:0] r_ir;
  logic [CNT_W-1:0]   r_retired;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_fault;
  logic [OP_W-1:0]    w_op;
  logic               w_jump;
  logic               w_short;
  logic               w_mem;
  logic               w_timeout;
  logic               w_pc_en;
  assign w_op      = r_ir[INSTR_W-1 -: OP_W];
  assign w_jump    = JUMP_MASK[w_op];
  assign w_short   = SHORT_MASK[w_op];
  assign w_mem     = MEM_MASK[w_op];
  // The last tolerated un-acked cycle is the one where the counter already reads MAX_WAIT-1.
  assign w_timeout = (MAX_WAIT > 0) && (r_wait == WAIT_W'(MAX_WAIT - 1));
  assign w_pc_en   = (r_state == S_WB) || (r_state == S_DECODE && w_jump);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = bus.run ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = bus.im_ack ? S_DECODE : w_timeout ? S_FAULT : S_FETCH;
      S_DECODE: w_next = w_jump ? (bus.run ? S_FETCH : S_IDLE) : w_short ? S_WB : S_EXEC;
      S_EXEC:   w_next = w_mem ? S_MEM : S_WB;
      S_MEM:    w_next = bus.dm_ack ? S_WB : w_timeout ? S_FAULT : S_MEM;
      S_WB:     w_next = bus.run ? S_FETCH : S_IDLE;
      default:  w_next = S_FAULT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_retired <= '0;
      r_fault   <= 1'b0;
      r_wait    <= '0;
    end else begin
      r_state   <= w_next;
      r_retired <= r_retired + CNT_W'(w_pc_en);
      r_fault   <= r_fault | (w_next == S_FAULT);
      if (r_state == S_FETCH && bus.im_ack) r_ir <= bus.instr;
      // Remaining in FETCH/MEMORY implies the ack was low this cycle.
      r_wait    <= (w_next != r_state) ? '0 :
                   (r_state == S_FETCH || r_state == S_MEM) ? r_wait + 1'b1 : r_wait;
    end
  end
  assign bus.im_req   = r_state == S_FETCH;
  assign bus.dm_req   = r_state == S_MEM;
  assign bus.rf_rd_en = r_state == S_DECODE;
  assign bus.alu_en   = r_state == S_EXEC;
  assign bus.rf_wr_en = (r_state == S_WB) && bus.cu_regw;
  assign bus.pc_en    = w_pc_en;
  assign bus.ir       = r_ir;
  assign bus.state    = r_state;
  assign bus.retired  = r_retired;
  assign bus.fault    = r_fault;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: random instruction stream scored against a per-instruction latency model, plus reset and timeout scenarios.
module tb_cpu_sequencer;
  localparam int N = 41;
  typedef struct {
    logic [15:0] instr;
    int          lat;
    int          im_cyc;
    int          dm_cyc;
    int          alu;
    int          wr;
    logic [3:0]  ret;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  cpu_sequencer_if #(.INSTR_W(16), .CNT_W(4)) bus ();
  cpu_sequencer #(.CNT_W(4), .MAX_WAIT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   sb_on = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [15:0] ins, input int di, input int dm, input bit regw, input int idx);
    exp_t e;
    logic [15:0] jm = 16'h1000;
    logic [15:0] sm = 16'h6000;
    logic [15:0] mm = 16'h80E0;
    int op = int'(ins[15:12]);
    e.instr = ins;
    e.im_cyc = di + 1;
    e.ret = 4'(idx % 16);
    e.dm_cyc = 0;
    if (jm[op]) begin
      e.lat = 2 + di; e.alu = 0; e.wr = 0;
    end else if (sm[op]) begin
      e.lat = 3 + di; e.alu = 0; e.wr = int'(regw);
    end else if (mm[op]) begin
      e.lat = 5 + di + dm; e.alu = 1; e.wr = int'(regw); e.dm_cyc = dm + 1;
    end else begin
      e.lat = 4 + di; e.alu = 1; e.wr = int'(regw);
    end
    return e;
  endfunction
  int         c_lat, c_im, c_dm, c_alu, c_rd;
  logic [2:0] prev = 3'd0;
  exp_t       me;
  always @(negedge clk) begin
    if (sb_on) begin
      if (bus.state == 3'd1 && prev != 3'd1) begin
        c_lat = 0; c_im = 0; c_dm = 0; c_alu = 0; c_rd = 0;
      end
      c_lat++;
      c_im  += int'(bus.im_req);
      c_dm  += int'(bus.dm_req);
      c_alu += int'(bus.alu_en);
      c_rd  += int'(bus.rf_rd_en);
      if (bus.pc_en) begin
        if (sbq.size() == 0) chk("sb_underflow", 32'(bus.pc_en), 0);
        else begin
          me = sbq.pop_front();
          chk("ir", 32'(bus.ir), 32'(me.instr));
          chk("latency", c_lat, me.lat);
          chk("im_req_cycles", c_im, me.im_cyc);
          chk("dm_req_cycles", c_dm, me.dm_cyc);
          chk("alu_en_cycles", c_alu, me.alu);
          chk("rf_rd_en_cycles", c_rd, 1);
          chk("rf_wr_en", 32'(bus.rf_wr_en), me.wr);
          chk("retired", 32'(bus.retired), 32'(me.ret));
        end
      end
    end
    prev = bus.state;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int   di, dm, w, cnt;
    bit   regw;
    exp_t e;
    logic [15:0] ins;
    bus.run = 0; bus.instr = '0; bus.im_ack = 0; bus.dm_ack = 0; bus.cu_regw = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_ir", 32'(bus.ir), 0);
    chk("rst_retired", 32'(bus.retired), 0);
    chk("rst_fault", 32'(bus.fault), 0);
    chk("rst_strobes", 32'({bus.im_req, bus.dm_req, bus.rf_rd_en, bus.alu_en, bus.rf_wr_en, bus.pc_en}), 0);
    repeat (3) @(negedge clk);
    chk("idle_hold", 32'(bus.state), 0);
    sb_on = 1;
    @(posedge clk); #1;
    bus.run = 1;
    for (int i = 0; i < N; i++) begin
      di = $urandom_range(0, 3);
      dm = $urandom_range(0, 3);
      regw = 1'($urandom_range(0, 1));
      ins = 16'($urandom);
      w = 0;
      while (!bus.im_req && w < 20) begin @(posedge clk); #1; w++; end
      if (!bus.im_req) begin chk("fetch_start", 32'(bus.im_req), 1); break; end
      repeat (di) begin bus.dm_ack = 1'($urandom); @(posedge clk); #1; end
      bus.im_ack = 1; bus.instr = ins; bus.cu_regw = regw; bus.dm_ack = 1'($urandom);
      if (i == N - 1) bus.run = 0;
      e = model(ins, di, dm, regw, i);
      sbq.push_back(e);
      @(posedge clk); #1;
      bus.im_ack = 0; bus.dm_ack = 0; bus.instr = 16'($urandom);
      if (e.dm_cyc > 0) begin
        w = 0;
        while (!bus.dm_req && w < 10) begin @(posedge clk); #1; w++; end
        if (!bus.dm_req) begin chk("mem_start", 32'(bus.dm_req), 1); break; end
        repeat (dm) begin @(posedge clk); #1; end
        bus.dm_ack = 1;
        @(posedge clk); #1;
        bus.dm_ack = 0;
      end
    end
    w = 0;
    do begin @(negedge clk); w++; end while (!(bus.state == 3'd0 && sbq.size() == 0) && w < 40);
    chk("end_idle", 32'(bus.state), 0);
    chk("sb_empty", sbq.size(), 0);
    chk("retired_wrap", 32'(bus.retired), N % 16);
    sb_on = 0;
    @(posedge clk); #1;
    bus.run = 1;
    w = 0;
    while (!bus.im_req && w < 10) begin @(posedge clk); #1; w++; end
    bus.im_ack = 1; bus.instr = 16'h5abc;
    @(posedge clk); #1;
    bus.im_ack = 0;
    w = 0;
    while (bus.state != 3'd4 && w < 10) begin @(posedge clk); #1; w++; end
    chk("reach_mem", 32'(bus.state), 4);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("mrst_state", 32'(bus.state), 0);
    chk("mrst_dm_req", 32'(bus.dm_req), 0);
    chk("mrst_retired", 32'(bus.retired), 0);
    chk("mrst_ir", 32'(bus.ir), 0);
    @(negedge clk);
    chk("mrst_refetch", 32'(bus.state), 1);
    cnt = 0;
    for (int k = 0; k < 30 && bus.state != 3'd7; k++) begin
      cnt += int'(bus.im_req);
      @(negedge clk);
    end
    chk("timeout_req_cycles", cnt, 8);
    chk("timeout_state", 32'(bus.state), 7);
    chk("timeout_fault", 32'(bus.fault), 1);
    @(posedge clk); #1;
    bus.im_ack = 1;
    repeat (3) @(negedge clk);
    chk("fault_sticky_state", 32'(bus.state), 7);
    chk("fault_sticky", 32'(bus.fault), 1);
    chk("fault_no_req", 32'(bus.im_req), 0);
    @(posedge clk); #1;
    rst = 0; bus.run = 0; bus.im_ack = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("fault_clear", 32'(bus.fault), 0);
    chk("fault_clear_state", 32'(bus.state), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Parametrised multi-cycle instruction sequencer for the 16-bit RISC core. It replaces the hard-coded FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK loop with a registered FSM driven by opcode-class masks. Instruction and data memory accesses use req/ack handshakes with a bounded wait and a fault trap, and the block adds run/halt control and a retired-instruction counter. It sits between the instruction memory, control unit, register file, ALU, data memory and pc_module, and drives their stage enables.

## Interface
- OP_W, 4 — opcode width; opcode is instr[INSTR_W-1 -: OP_W]
- INSTR_W, 16 — instruction width
- CNT_W, 32 — retired counter width
- MAX_WAIT, 8 — max cycles a req may stay un-acked; 0 disables the timeout
- MEM_MASK, 16'h80E0 — bit k set: opcode k takes the MEMORY path (LW/LB/SW/SV)
- JUMP_MASK, 16'h1000 — bit k set: opcode k completes in DECODE (JMP)
- SHORT_MASK, 16'h6000 — bit k set: opcode k skips EXECUTE (CALL/RET)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset
- run  in  1  1 = execute; 0 = stop at the next instruction boundary
- instr  in  INSTR_W  instruction memory read data
- im_ack  in  1  instruction memory ack; instr valid in the same cycle
- dm_ack  in  1  data memory access complete
- cu_regw  in  1  control unit register write request
- im_req  out  1  instruction fetch request
- dm_req  out  1  data memory access request
- rf_rd_en  out  1  register file read enable
- alu_en  out  1  ALU enable
- rf_wr_en  out  1  register write strobe
- pc_en  out  1  pc_module load strobe
- ir  out  INSTR_W  latched instruction
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, FAULT=7
- retired  out  CNT_W  count of completed instructions
- fault  out  1  handshake timeout; sticky until reset

## Operation
- Reset (rst=0 at an edge): state=IDLE, ir=0, retired=0, fault=0, wait_cnt=0. All strobes decode to 0. Reset overrides every state, including an in-flight access.
- Strobes are Moore decodes of state:
  - im_req = FETCH; dm_req = MEMORY; rf_rd_en = DECODE; alu_en = EXECUTE.
  - rf_wr_en = WRITEBACK & cu_regw.
  - pc_en = WRITEBACK, or DECODE with JUMP_MASK[op].
- Let op = ir[INSTR_W-1 -: OP_W]. Mask precedence: JUMP > SHORT > MEM.
- Transitions:
  - IDLE: run=1 -> FETCH; otherwise stay.
  - FETCH: im_ack=1 -> latch ir<=instr, go to DECODE.
  - DECODE: JUMP -> FETCH (IDLE if run=0); SHORT -> WRITEBACK; else -> EXECUTE.
  - EXECUTE: MEM -> MEMORY; else -> WRITEBACK.
  - MEMORY: dm_ack=1 -> WRITEBACK.
  - WRITEBACK: run=1 -> FETCH; run=0 -> IDLE.
  - FAULT: absorbing until reset.
- wait_cnt:
  - Cleared on entry to FETCH or MEMORY.
  - Increments each cycle the req is high and its ack is low.
  - If ack is low while wait_cnt==MAX_WAIT-1 (MAX_WAIT>0): next state is FAULT and fault is set to 1.
- Acks arriving outside their request state are ignored. An ack in the first cycle of the state is accepted.
- retired increments by 1 in every cycle pc_en=1 and wraps modulo 2^CNT_W.

## Timing
- Each state occupies at least 1 cycle.
- Zero-wait instruction latencies (cycles from FETCH entry to the next FETCH):
  - ALU/branch: 4
  - MEM: 5
  - SHORT: 3
  - JUMP: 2
- Each un-acked cycle adds 1.
- ir is valid from the first DECODE cycle and is held until the next fetch ack.
- A run deassertion mid-instruction has no effect until the boundary (WRITEBACK or JUMP DECODE).
- A timeout fires after exactly MAX_WAIT un-acked cycles in the state. fault is visible in the cycle state first reads 7.

## Test plan
- Opcode 0, im_ack tied 1, run=1: state 1,2,3,5,1; rf_wr_en=cu_regw and pc_en=1 in cycle 4 only; retired 0->1.
- Opcode 5 with dm_ack raised on the 3rd MEMORY cycle: state 1,2,3,4,4,4,5; dm_req high for exactly 3 cycles; instruction takes 7 cycles.
- Opcode 12 (JMP): state 1,2,1; pc_en=1 in DECODE; alu_en and rf_wr_en never asserted. Opcode 13: state 1,2,5.
- MAX_WAIT=8 with im_ack held 0: im_req high for 8 cycles, then state=7 and fault=1. Both stay set after im_ack rises, and clear only on rst=0.
- rst=0 for one cycle during MEMORY: next cycle state=0, dm_req=0, retired=0, ir=0. With run=1 the fetch restarts one cycle later.
- CNT_W=4, 17 back-to-back ALU ops, then run dropped during the 17th: retired wraps 15->0->1 and state ends in IDLE after that instruction's WRITEBACK.
